// File: rtl/glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : glitch_sequencer
// Description : Arms on request, clears and enables an external event counter,
//               waits for a synchronised trigger edge, then emits a delayed
//               train of glitch pulses with programmable width, gap and count.
// Revision    : 1.0 - initial release
// ============================================================================
module glitch_sequencer #(
  parameter int WIDTH  = 32,
  parameter int RWIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              trigger_i,
  input  logic [WIDTH-1:0]  delay_i,
  input  logic [WIDTH-1:0]  width_i,
  input  logic [WIDTH-1:0]  gap_i,
  input  logic [RWIDTH-1:0] repeat_i,
  output logic              counter_rst_o,
  output logic              counter_en_o,
  output logic              glitch_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_DELAY     = 3'd3,
    S_PULSE     = 3'd4,
    S_GAP       = 3'd5,
    S_DONE      = 3'd6,
    S_BAD       = 3'd7
  } state_t;

  localparam logic [WIDTH-1:0]  C_ONE_W = WIDTH'(1);
  localparam logic [RWIDTH-1:0] C_ONE_R = RWIDTH'(1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_delay;
  logic [WIDTH-1:0]   r_width;
  logic [WIDTH-1:0]   r_gap;
  logic [RWIDTH-1:0]  r_rem;
  logic               r_glitch;
  logic               r_done;
  logic               r_crst;
  logic               r_cen;

  logic               r_trig_s1;
  logic               r_trig_s2;
  logic               r_trig_s3;
  logic               w_trig_rise;

  logic [WIDTH-1:0]   w_width_eff;
  logic [WIDTH-1:0]   w_gap_eff;

  // Zero width/gap are treated as one cycle so a pulse or gap is never skipped.
  assign w_width_eff = (r_width == '0) ? C_ONE_W : r_width;
  assign w_gap_eff   = (r_gap   == '0) ? C_ONE_W : r_gap;

  // Two-flop synchroniser for the asynchronous trigger, third flop for edge detect.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
      r_trig_s3 <= 1'b0;
    end else begin
      r_trig_s1 <= trigger_i;
      r_trig_s2 <= r_trig_s1;
      r_trig_s3 <= r_trig_s2;
    end
  end

  // A level held high produces no rise because s2 and s3 agree.
  assign w_trig_rise = r_trig_s2 & ~r_trig_s3;

  // Sequencer: outputs are registered alongside the state so they change on
  // the same edge the state does (glitch_o rises as PULSE is entered).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_delay  <= '0;
      r_width  <= '0;
      r_gap    <= '0;
      r_rem    <= '0;
      r_glitch <= 1'b0;
      r_done   <= 1'b0;
      r_crst   <= 1'b1;
      r_cen    <= 1'b0;
    end else begin
      r_glitch <= 1'b0;
      r_done   <= 1'b0;
      r_crst   <= 1'b0;
      r_cen    <= 1'b0;
      if (abort_i) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (arm_i) begin
              r_delay <= delay_i;
              r_width <= width_i;
              r_gap   <= gap_i;
              r_rem   <= (repeat_i == '0) ? C_ONE_R : repeat_i;
              r_state <= S_CLEAR;
              r_crst  <= 1'b1;
            end
          end
          S_CLEAR: begin
            r_state <= S_WAIT_TRIG;
            r_cen   <= 1'b1;
          end
          S_WAIT_TRIG: begin
            if (w_trig_rise) begin
              if (r_delay == '0) begin
                r_state  <= S_PULSE;
                r_cnt    <= w_width_eff;
                r_glitch <= 1'b1;
              end else begin
                r_state <= S_DELAY;
                r_cnt   <= r_delay;
              end
            end else begin
              r_cen <= 1'b1;
            end
          end
          S_DELAY: begin
            if (r_cnt <= C_ONE_W) begin
              r_state  <= S_PULSE;
              r_cnt    <= w_width_eff;
              r_glitch <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_ONE_W;
            end
          end
          S_PULSE: begin
            if (r_cnt <= C_ONE_W) begin
              r_rem <= (r_rem == '0) ? '0 : (r_rem - C_ONE_R);
              if (r_rem > C_ONE_R) begin
                r_state <= S_GAP;
                r_cnt   <= w_gap_eff;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt    <= r_cnt - C_ONE_W;
              r_glitch <= 1'b1;
            end
          end
          S_GAP: begin
            if (r_cnt <= C_ONE_W) begin
              r_state  <= S_PULSE;
              r_cnt    <= w_width_eff;
              r_glitch <= 1'b1;
            end else begin
              r_cnt <= r_cnt - C_ONE_W;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign counter_rst_o = r_crst;
  assign counter_en_o  = r_cen;
  assign glitch_o      = r_glitch;
  assign done_o        = r_done;
  assign busy_o        = (r_state != S_IDLE);
  assign state_o       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_glitch_sequencer
// Description : Directed self-checking bench for glitch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_sequencer;

  localparam int WIDTH  = 32;
  localparam int RWIDTH = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DELAY = 3'd3;
  localparam logic [2:0] ST_PULSE = 3'd4;
  localparam logic [2:0] ST_GAP   = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;

  logic              clk;
  logic              rst_n;
  logic              arm;
  logic              abort;
  logic              trigger;
  logic [WIDTH-1:0]  delay;
  logic [WIDTH-1:0]  width;
  logic [WIDTH-1:0]  gap;
  logic [RWIDTH-1:0] rpt;
  logic              crst;
  logic              cen;
  logic              glitch;
  logic              busy;
  logic              done;
  logic [2:0]        state;

  int n_cmp = 0;
  int n_err = 0;

  glitch_sequencer #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) u_dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .arm_i         (arm),
    .abort_i       (abort),
    .trigger_i     (trigger),
    .delay_i       (delay),
    .width_i       (width),
    .gap_i         (gap),
    .repeat_i      (rpt),
    .counter_rst_o (crst),
    .counter_en_o  (cen),
    .glitch_o      (glitch),
    .busy_o        (busy),
    .done_o        (done),
    .state_o       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Count consecutive samples spent in state st; also count samples whose
  // glitch level disagrees with "high only in PULSE".
  task automatic count_state(input logic [2:0] st, output int n, output int bad);
    n = 0;
    bad = 0;
    while (state === st && n < 500) begin
      n++;
      if (glitch !== (st == ST_PULSE)) bad++;
      step();
    end
  endtask

  // Arm with given parameters; returns with arm already dropped and the
  // DUT sampled one cycle after the arming edge (CLEAR expected).
  task automatic arm_seq(input int d, input int w, input int g, input int r);
    delay = WIDTH'(d);
    width = WIDTH'(w);
    gap   = WIDTH'(g);
    rpt   = RWIDTH'(r);
    arm   = 1'b1;
    step();
    arm   = 1'b0;
  endtask

  // Raise trigger and measure edges until the state leaves WAIT_TRIG.
  task automatic fire_trigger(output int lat);
    trigger = 1'b1;
    lat = 0;
    do begin
      step();
      lat++;
    end while (state === ST_WAIT && lat < 12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_cmp++; if (glitch !== 1'b0) begin n_err++; $display("FAIL reset_glitch: got %b want 0", glitch); end
    n_cmp++; if (crst !== 1'b1) begin n_err++; $display("FAIL reset_crst: got %b want 1", crst); end
    n_cmp++; if (cen !== 1'b0) begin n_err++; $display("FAIL reset_cen: got %b want 0", cen); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_cmp++; if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want 0", state); end
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (crst !== 1'b0) begin n_err++; $display("FAIL reset_release_crst: got %b want 0", crst); end
    n_cmp++; if (state !== ST_IDLE) begin n_err++; $display("FAIL reset_release_state: got %0d want 0", state); end
  endtask

  task automatic test_single();
    int lat, n, bad;
    arm_seq(5, 3, 0, 1);
    n_cmp++; if (state !== ST_CLEAR || crst !== 1'b1) begin n_err++; $display("FAIL single_clear: got state %0d crst %b want 1/1", state, crst); end
    // Arm outside IDLE must be ignored; changed inputs must not matter.
    arm = 1'b1; delay = 40; width = 9;
    step();
    arm = 1'b0;
    n_cmp++; if (state !== ST_WAIT || cen !== 1'b1 || crst !== 1'b0) begin n_err++; $display("FAIL single_wait: got state %0d cen %b crst %b want 2/1/0", state, cen, crst); end
    step();
    n_cmp++; if (state !== ST_WAIT) begin n_err++; $display("FAIL single_wait_hold: got %0d want 2", state); end
    fire_trigger(lat);
    n_cmp++; if (lat < 3 || lat > 4) begin n_err++; $display("FAIL single_latency: got %0d want 3..4", lat); end
    n_cmp++; if (cen !== 1'b0) begin n_err++; $display("FAIL single_cen_off: got %b want 0", cen); end
    count_state(ST_DELAY, n, bad);
    n_cmp++; if (n !== 5) begin n_err++; $display("FAIL single_delay_len: got %0d want 5", n); end
    count_state(ST_PULSE, n, bad);
    n_cmp++; if (n !== 3) begin n_err++; $display("FAIL single_pulse_len: got %0d want 3", n); end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL single_glitch_level: got %0d bad samples want 0", bad); end
    n_cmp++; if (state !== ST_DONE || done !== 1'b1) begin n_err++; $display("FAIL single_done: got state %0d done %b want 6/1", state, done); end
    step();
    n_cmp++; if (state !== ST_IDLE || done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got state %0d done %b busy %b want 0/0/0", state, done, busy); end
    trigger = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_repeat();
    int lat, n, bad, badsum;
    int exp_len [5] = '{2, 4, 2, 4, 2};
    logic [2:0] exp_st [5] = '{ST_PULSE, ST_GAP, ST_PULSE, ST_GAP, ST_PULSE};
    badsum = 0;
    arm_seq(0, 2, 4, 3);
    step();
    fire_trigger(lat);
    n_cmp++; if (state !== ST_PULSE || glitch !== 1'b1) begin n_err++; $display("FAIL repeat_direct_pulse: got state %0d glitch %b want 4/1", state, glitch); end
    for (int i = 0; i < 5; i++) begin
      count_state(exp_st[i], n, bad);
      badsum += bad;
      n_cmp++; if (n !== exp_len[i]) begin n_err++; $display("FAIL repeat_seg%0d_len: got %0d want %0d", i, n, exp_len[i]); end
    end
    n_cmp++; if (badsum !== 0) begin n_err++; $display("FAIL repeat_glitch_level: got %0d bad samples want 0", badsum); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL repeat_done: got %b want 1", done); end
    step();
    trigger = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_zero();
    int lat, n, bad;
    arm_seq(0, 0, 0, 0);
    step();
    fire_trigger(lat);
    count_state(ST_PULSE, n, bad);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL zero_pulse_len: got %0d want 1", n); end
    n_cmp++; if (state !== ST_DONE || done !== 1'b1) begin n_err++; $display("FAIL zero_done: got state %0d done %b want 6/1", state, done); end
    step();
    trigger = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_abort();
    int lat, n, bad, seen;
    arm_seq(1, 2, 4, 5);
    step();
    fire_trigger(lat);
    count_state(ST_DELAY, n, bad);
    count_state(ST_PULSE, n, bad);
    step();
    n_cmp++; if (state !== ST_GAP) begin n_err++; $display("FAIL abort_in_gap: got %0d want 5", state); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_cmp++; if (state !== ST_IDLE || glitch !== 1'b0) begin n_err++; $display("FAIL abort_idle: got state %0d glitch %b want 0/0", state, glitch); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0 || glitch !== 1'b0 || state !== ST_IDLE) seen++;
      step();
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL abort_quiet: got %0d active samples want 0", seen); end
    trigger = 1'b0;
    // Arm and abort together in IDLE: abort wins.
    delay = 3; width = 1; gap = 1; rpt = 1;
    arm = 1'b1; abort = 1'b1;
    step();
    arm = 1'b0; abort = 1'b0;
    n_cmp++; if (state !== ST_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL arm_abort_idle: got state %0d busy %b want 0/0", state, busy); end
    repeat (3) step();
  endtask

  task automatic test_latch();
    int lat, n, bad, moved;
    trigger = 1'b1;
    repeat (5) step();
    arm_seq(0, 1, 0, 1);
    delay = 100;
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (state !== ST_WAIT) moved++;
    end
    n_cmp++; if (moved !== 0) begin n_err++; $display("FAIL latch_held_trigger: got %0d samples outside WAIT_TRIG want 0", moved); end
    trigger = 1'b0;
    repeat (4) step();
    n_cmp++; if (state !== ST_WAIT) begin n_err++; $display("FAIL latch_fall_ignored: got %0d want 2", state); end
    fire_trigger(lat);
    n_cmp++; if (state !== ST_PULSE || lat < 3 || lat > 4) begin n_err++; $display("FAIL latch_delay0_used: got state %0d latency %0d want 4 in 3..4", state, lat); end
    count_state(ST_PULSE, n, bad);
    n_cmp++; if (n !== 1) begin n_err++; $display("FAIL latch_pulse_len: got %0d want 1", n); end
    step();
    trigger = 1'b0;
    repeat (5) step();
  endtask

  task automatic test_reset_mid_pulse();
    int lat;
    arm_seq(0, 20, 0, 1);
    step();
    fire_trigger(lat);
    step();
    n_cmp++; if (glitch !== 1'b1) begin n_err++; $display("FAIL rstpulse_pre_glitch: got %b want 1", glitch); end
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (glitch !== 1'b0 || crst !== 1'b1 || cen !== 1'b0) begin n_err++; $display("FAIL rstpulse_async: got glitch %b crst %b cen %b want 0/1/0", glitch, crst, cen); end
    n_cmp++; if (state !== ST_IDLE || busy !== 1'b0) begin n_err++; $display("FAIL rstpulse_state: got %0d busy %b want 0/0", state, busy); end
    trigger = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (state !== ST_IDLE || crst !== 1'b0 || glitch !== 1'b0) begin n_err++; $display("FAIL rstpulse_release: got state %0d crst %b glitch %b want 0/0/0", state, crst, glitch); end
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trigger = 1'b0;
    delay = '0; width = '0; gap = '0; rpt = '0;
    test_reset();
    test_single();
    test_repeat();
    test_zero();
    test_abort();
    test_latch();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
